// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern path: serializer state encoding,
// default word width and the detector pattern used by the benches.
package seq_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [3:0] DET_PATTERN = 4'b1011;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01
   } state_e;

endpackage : seq_pkg

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding the pattern detector: valid/ready word
// intake, one-word holding register, gapless back-to-back shifting, frame markers.
module piso_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Bit that leaves the word first.
   function automatic logic lead_bit(input logic [WIDTH-1:0] word);
      if (MSB_FIRST) begin
         lead_bit = word[WIDTH-1];
      end else begin
         lead_bit = word[0];
      end
   endfunction

   // Word with its leading bit consumed.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
      if (MSB_FIRST) begin
         advance = {word[WIDTH-2:0], 1'b0};
      end else begin
         advance = {1'b0, word[WIDTH-1:1]};
      end
   endfunction

   state_e           state_r, state_s;
   logic [WIDTH-1:0] shift_r, shift_s;
   logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
   logic [WIDTH-1:0] hold_r, hold_s;
   logic             hold_full_r, hold_full_s;
   logic             ser_out_r, ser_out_s;
   logic             ser_valid_r, ser_valid_s;
   logic             frame_start_r, frame_start_s;
   logic             frame_end_r, frame_end_s;
   logic             accept_s;
   logic             start_s;
   logic [WIDTH-1:0] start_word_s;

   assign load_ready  = !hold_full_r;
   assign accept_s    = load_valid && !hold_full_r;
   assign busy        = (state_r == SHIFT) || hold_full_r;
   assign ser_out     = ser_out_r;
   assign ser_valid   = ser_valid_r;
   assign frame_start = frame_start_r;
   assign frame_end   = frame_end_r;

   // Next-state, shifting, holding-register and registered-output decode.
   always_comb begin
      state_s       = state_r;
      shift_s       = shift_r;
      bit_cnt_s     = bit_cnt_r;
      hold_s        = hold_r;
      hold_full_s   = hold_full_r;
      ser_out_s     = ser_out_r;
      ser_valid_s   = ser_valid_r;
      frame_start_s = 1'b0;
      frame_end_s   = 1'b0;
      start_s       = 1'b0;
      start_word_s  = load_data;

      case (state_r)
         IDLE: begin
            if (accept_s) begin
               start_s      = 1'b1;
               start_word_s = load_data;
            end else begin
               ser_valid_s = 1'b0;
               ser_out_s   = IDLE_BIT;
            end
         end
         SHIFT: begin
            if (bit_cnt_r != CNT_ZERO) begin
               ser_out_s   = lead_bit(shift_r);
               shift_s     = advance(shift_r);
               bit_cnt_s   = bit_cnt_r - CNT_ONE;
               frame_end_s = (bit_cnt_r == CNT_ONE);
               if (accept_s) begin
                  hold_s      = load_data;
                  hold_full_s = 1'b1;
               end else begin
                  hold_s = hold_r;
               end
            end else if (hold_full_r) begin
               start_s      = 1'b1;
               start_word_s = hold_r;
               hold_full_s  = 1'b0;
            end else if (accept_s) begin
               // Bypass: a word offered on the last bit goes straight to the shifter.
               start_s      = 1'b1;
               start_word_s = load_data;
            end else begin
               state_s     = IDLE;
               ser_valid_s = 1'b0;
               ser_out_s   = IDLE_BIT;
            end
         end
         default: begin
            state_s     = IDLE;
            bit_cnt_s   = CNT_ZERO;
            hold_full_s = 1'b0;
            ser_valid_s = 1'b0;
            ser_out_s   = IDLE_BIT;
         end
      endcase

      if (start_s) begin
         state_s       = SHIFT;
         shift_s       = advance(start_word_s);
         bit_cnt_s     = CNT_LAST;
         ser_out_s     = lead_bit(start_word_s);
         ser_valid_s   = 1'b1;
         frame_start_s = 1'b1;
      end else begin
         frame_start_s = 1'b0;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         shift_r       <= {WIDTH{1'b0}};
         bit_cnt_r     <= CNT_ZERO;
         hold_r        <= {WIDTH{1'b0}};
         hold_full_r   <= 1'b0;
         ser_out_r     <= IDLE_BIT;
         ser_valid_r   <= 1'b0;
         frame_start_r <= 1'b0;
         frame_end_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         shift_r       <= shift_s;
         bit_cnt_r     <= bit_cnt_s;
         hold_r        <= hold_s;
         hold_full_r   <= hold_full_s;
         ser_out_r     <= ser_out_s;
         ser_valid_r   <= ser_valid_s;
         frame_start_r <= frame_start_s;
         frame_end_r   <= frame_end_s;
      end
   end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share one input
// stream and are compared against a bit-queue reference model every cycle.
module tb_piso_serializer;
   import seq_pkg::*;

   localparam int W = 8;
   localparam bit IDLE_B = 1'b0;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] load_data;
   logic         load_valid;
   logic         rdy_m, out_m, val_m, fs_m, fe_m, busy_m;
   logic         rdy_l, out_l, val_l, fs_l, fe_l, busy_l;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_B)) dut_m (
      .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
      .load_ready(rdy_m), .ser_out(out_m), .ser_valid(val_m),
      .frame_start(fs_m), .frame_end(fe_m), .busy(busy_m));

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_B)) dut_l (
      .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
      .load_ready(rdy_l), .ser_out(out_l), .ser_valid(val_l),
      .frame_start(fs_l), .frame_end(fe_l), .busy(busy_l));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic b;
      logic fs;
      logic fe;
   } sbit_t;

   // Model: bits still to be driven, plus the bit currently on the wire.
   sbit_t qm[$];
   sbit_t ql[$];
   sbit_t cur_m, cur_l;
   logic  vm, vl;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] cap_m, cap_l;
   int          cnt_m, cnt_l;
   logic        last_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_ready();
      return (qm.size() < W);
   endfunction

   task automatic check_outputs();
      logic er;
      er = model_ready();
      chk("msb_valid", {31'd0, val_m}, {31'd0, vm});
      chk("msb_out", {31'd0, out_m}, {31'd0, vm ? cur_m.b : IDLE_B});
      chk("msb_fstart", {31'd0, fs_m}, {31'd0, vm && cur_m.fs});
      chk("msb_fend", {31'd0, fe_m}, {31'd0, vm && cur_m.fe});
      chk("msb_ready", {31'd0, rdy_m}, {31'd0, er});
      chk("msb_busy", {31'd0, busy_m}, {31'd0, vm || (qm.size() > 0)});
      chk("lsb_valid", {31'd0, val_l}, {31'd0, vl});
      chk("lsb_out", {31'd0, out_l}, {31'd0, vl ? cur_l.b : IDLE_B});
      chk("lsb_fstart", {31'd0, fs_l}, {31'd0, vl && cur_l.fs});
      chk("lsb_fend", {31'd0, fe_l}, {31'd0, vl && cur_l.fe});
      chk("lsb_ready", {31'd0, rdy_l}, {31'd0, er});
      chk("lsb_busy", {31'd0, busy_l}, {31'd0, vl || (ql.size() > 0)});
   endtask

   // One clock: apply current inputs, advance the model, check at the falling edge.
   task automatic tick(output logic acc);
      sbit_t e;
      acc = load_valid && model_ready();
      @(posedge clk);
      if (acc) begin
         for (int i = 0; i < W; i++) begin
            e.fs = (i == 0);
            e.fe = (i == W - 1);
            e.b  = load_data[W-1-i];
            qm.push_back(e);
            e.b  = load_data[i];
            ql.push_back(e);
         end
      end
      vm = (qm.size() > 0);
      if (vm) cur_m = qm.pop_front();
      vl = (ql.size() > 0);
      if (vl) cur_l = ql.pop_front();
      @(negedge clk);
      check_outputs();
      if (val_m) begin
         cap_m = {cap_m[30:0], out_m};
         cnt_m++;
      end
      if (val_l) begin
         cap_l = {cap_l[30:0], out_l};
         cnt_l++;
      end
   endtask

   task automatic idle(input int n);
      logic a;
      load_valid = 1'b0;
      for (int i = 0; i < n; i++) tick(a);
   endtask

   // Present a word and keep it stable until the model says it was taken.
   task automatic offer(input logic [W-1:0] d);
      logic a;
      int   k;
      load_valid = 1'b1;
      load_data  = d;
      a = 1'b0;
      k = 0;
      while (!a && k < 40) begin
         tick(a);
         k++;
      end
      chk("offer_taken", {31'd0, a}, 32'd1);
   endtask

   task automatic clear_cap();
      cap_m = 32'd0;
      cap_l = 32'd0;
      cnt_m = 0;
      cnt_l = 0;
   endtask

   task automatic model_reset();
      qm.delete();
      ql.delete();
      vm = 1'b0;
      vl = 1'b0;
   endtask

   initial begin
      int hits;
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      cur_m      = '0;
      cur_l      = '0;
      model_reset();
      clear_cap();
      repeat (2) @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // Single word, MSB-first stream 1,0,1,1,0,0,0,0 then idle.
      clear_cap();
      offer(8'hB0);
      idle(9);
      chk("single_cnt", cnt_m, 32'd8);
      chk("single_bits", cap_m, 32'h0000_00B0);
      hits = 0;
      for (int i = 0; i <= 4; i++) begin
         if (((cap_m >> i) & 32'hF) == {28'd0, DET_PATTERN}) hits++;
      end
      chk("single_detect", hits, 32'd1);

      // Back-to-back: second word absorbed by the holding register.
      clear_cap();
      offer(8'hA5);
      offer(8'h3C);
      idle(18);
      chk("b2b_cnt", cnt_m, 32'd16);
      chk("b2b_bits_m", cap_m, 32'h0000_A53C);
      chk("b2b_bits_l", cap_l, 32'h0000_A53C);

      // Bypass: second word offered on the last-bit cycle of the first.
      clear_cap();
      offer(8'hA5);
      idle(7);
      offer(8'h3C);
      idle(10);
      chk("bypass_cnt", cnt_m, 32'd16);
      chk("bypass_bits", cap_m, 32'h0000_A53C);

      // Backpressure: three words with valid held high throughout.
      clear_cap();
      offer(8'h11);
      offer(8'h22);
      offer(8'h33);
      idle(26);
      chk("bp_cnt", cnt_m, 32'd24);
      chk("bp_bits_m", cap_m, 32'h0011_2233);
      chk("bp_bits_l", cap_l, 32'h0088_44CC);

      // Reset in the middle of a word.
      clear_cap();
      offer(8'hFF);
      idle(2);
      chk("pre_rst_cnt", cnt_m, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {30'd0, val_m, val_l}, 32'd0);
      chk("rst_out", {30'd0, out_m, out_l}, {30'd0, IDLE_B, IDLE_B});
      chk("rst_busy", {30'd0, busy_m, busy_l}, 32'd0);
      chk("rst_ready", {30'd0, rdy_m, rdy_l}, 32'd3);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      clear_cap();
      idle(10);
      chk("post_rst_cnt", cnt_m, 32'd0);

      // LSB-first: 8'h0D goes out as 1,0,1,1,0,0,0,0.
      clear_cap();
      offer(8'h0D);
      idle(9);
      chk("lsb_bits", cap_l, 32'h0000_00B0);
      chk("lsb_msb_bits", cap_m, 32'h0000_000D);

      // Random traffic under the valid-stable rule.
      last_acc = 1'b1;
      load_valid = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if (!load_valid || last_acc) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = W'($urandom);
         end
         tick(last_acc);
      end
      idle(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_piso_serializer
